// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scan path.
package seg_pkg;
  localparam int NUM_DIGITS = 4;

  typedef logic [6:0] seg_t;
  typedef logic [1:0] digit_idx_t;

  localparam seg_t       SEG_OFF = 7'b0000000;
  localparam logic [3:0] AN_OFF  = 4'b1111;

  // Standard glyphs emitted by the upstream pattern source.
  localparam seg_t GLYPH_0 = 7'b0000111;
  localparam seg_t GLYPH_1 = 7'b1111010;
  localparam seg_t GLYPH_2 = 7'b1000110;
  localparam seg_t GLYPH_3 = 7'b1010101;

  // One output-stage drive word: segment bus plus active-low digit enables.
  typedef struct packed {
    seg_t       seg;
    logic [3:0] an;
  } drive_t;
endpackage

// File: rtl/scan_prescaler.sv
// Free-running 0..DIV-1 prescaler with a slot-boundary tick on the last count.
module scan_prescaler #(
  parameter int DIV = 50000,
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1
) (
  input  logic          clk,
  input  logic          rst,
  output logic          tick,
  output logic [CW-1:0] count
);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  // Count up and wrap to zero after the last slot cycle.
  always_ff @(posedge clk) begin
    if (rst)                count <= '0;
    else if (count == LAST) count <= '0;
    else                    count <= count + 1'b1;
  end

  // Tick is decoded straight off the count and held low while in reset.
  assign tick = ~rst & (count == LAST);
endmodule

// File: rtl/seg_scan_mux.sv
// Four-digit seven-segment scan multiplexer.
// Optional anti-ghosting dead time at the start of each slot: SEG_SCAN_BLANK_EN.
module seg_scan_mux
  import seg_pkg::*;
#(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [1:0] wr_addr,
  input  logic [6:0] seg_in,
  input  logic       blank,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       tick
);
  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] BLANK_C = CW'(BLANK_CYCLES);
`ifdef SEG_SCAN_BLANK_EN
  localparam bit DEAD_EN = 1'b1;
`else
  localparam bit DEAD_EN = 1'b0;
`endif

  logic [CW-1:0]               count;
  digit_idx_t                  idx;
  seg_t [NUM_DIGITS-1:0]       pat;
  logic                        dead;
  drive_t                      drv_d, drv_q;

  scan_prescaler #(.DIV(REFRESH_DIV)) u_pre (
    .clk   (clk),
    .rst   (rst),
    .tick  (tick),
    .count (count)
  );

  // Dead time covers the first BLANK_CYCLES counts of every slot when enabled.
  assign dead = DEAD_EN & (count < BLANK_C);

  // Digit index steps once per slot; 2-bit overflow gives the 3->0 wrap.
  always_ff @(posedge clk) begin
    if (rst)       idx <= '0;
    else if (tick) idx <= idx + 1'b1;
  end

  // Digit register file; reset clears every stored pattern.
  always_ff @(posedge clk) begin
    if (rst)        pat          <= '{default: SEG_OFF};
    else if (wr_en) pat[wr_addr] <= seg_in;
  end

  // Next drive word: all off when blanked, otherwise the current digit.
  always_comb begin
    drv_d.seg = SEG_OFF;
    drv_d.an  = AN_OFF;
    if (!(blank || dead)) begin
      drv_d.seg = pat[idx];
      drv_d.an  = ~(4'b0001 << idx);
    end
  end

  // Registered output stage, one cycle behind index/pattern state.
  always_ff @(posedge clk) begin
    if (rst) drv_q <= '{seg: SEG_OFF, an: AN_OFF};
    else     drv_q <= drv_d;
  end

  assign seg = drv_q.seg;
  assign an  = drv_q.an;
endmodule

// File: tb/tb_seg_scan_mux.sv
// Scoreboard bench for seg_scan_mux with REFRESH_DIV=4, BLANK_CYCLES=1.
module tb_seg_scan_mux;
  import seg_pkg::*;

  localparam int DIV = 4;
  localparam int BLK = 1;
`ifdef SEG_SCAN_BLANK_EN
  localparam bit DEAD = 1'b1;
`else
  localparam bit DEAD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [1:0] wr_addr = '0;
  logic [6:0] seg_in = '0;
  logic       blank = 1'b0;
  logic [6:0] seg;
  logic [3:0] an;
  logic       tick;

  seg_scan_mux #(.REFRESH_DIV(DIV), .BLANK_CYCLES(BLK)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr),
    .seg_in(seg_in), .blank(blank), .seg(seg), .an(an), .tick(tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] seg;
    logic [3:0] an;
    logic       tick;
  } exp_t;

  exp_t       q[$];
  int         total = 0;
  int         bad = 0;

  // Reference: n = clock edges since reset released; slot = n / DIV.
  int         n = 0;
  logic [6:0] mpat[4];

  // Drive one cycle of inputs and queue what the DUT must show after the edge.
  task automatic cyc(input bit r, input bit w, input logic [1:0] a,
                     input logic [6:0] d, input bit b);
    exp_t       e;
    logic [3:0] one;
    int         ph, dg;
    @(negedge clk);
    rst = r; wr_en = w; wr_addr = a; seg_in = d; blank = b;
    one = 4'b0001;
    if (r) begin
      e.seg = 7'h00; e.an = 4'hF; e.tick = 1'b0;
      n = 0;
      for (int i = 0; i < 4; i++) mpat[i] = 7'h00;
    end else begin
      ph = n % DIV;
      dg = (n / DIV) % 4;
      if (b || (DEAD && ph < BLK)) begin
        e.seg = 7'h00; e.an = 4'hF;
      end else begin
        e.seg = mpat[dg]; e.an = ~(one << dg);
      end
      if (w) mpat[a] = d;
      n++;
      e.tick = ((n % DIV) == DIV - 1);
    end
    q.push_back(e);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cyc(1'b0, 1'b0, 2'd0, 7'h00, 1'b0);
  endtask

  // Advance until the next edge sees digit dg at prescaler phase ph.
  task automatic go_to(input int dg, input int ph);
    int k = 0;
    while (!(((n / DIV) % 4) == dg && (n % DIV) == ph) && k < 64) begin
      idle(1);
      k++;
    end
    total++;
    if (k >= 64) begin
      bad++;
      $display("FAIL go_to: digit %0d phase %0d not reached, at n=%0d", dg, ph, n);
    end
  endtask

  // Monitor: every sampled cycle with a pending expectation is compared.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        total += 3;
        if (seg !== e.seg) begin
          bad++;
          $display("FAIL seg @%0t: got %h want %h", $time, seg, e.seg);
        end
        if (an !== e.an) begin
          bad++;
          $display("FAIL an @%0t: got %b want %b", $time, an, e.an);
        end
        if (tick !== e.tick) begin
          bad++;
          $display("FAIL tick @%0t: got %b want %b", $time, tick, e.tick);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 4; i++) mpat[i] = 7'h00;
    // Reset and first frame with the standard glyphs.
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 2'd0, 7'h00, 1'b0);
    cyc(1'b0, 1'b1, 2'd0, GLYPH_0, 1'b0);
    cyc(1'b0, 1'b1, 2'd1, GLYPH_1, 1'b0);
    cyc(1'b0, 1'b1, 2'd2, GLYPH_2, 1'b0);
    cyc(1'b0, 1'b1, 2'd3, GLYPH_3, 1'b0);
    idle(20);
    // Live write to the displayed digit, away from a tick.
    go_to(2, 1);
    cyc(1'b0, 1'b1, 2'd2, 7'h7F, 1'b0);
    idle(2);
    // Write to the next digit on the very edge the index moves onto it.
    go_to(2, 3);
    cyc(1'b0, 1'b1, 2'd3, 7'h11, 1'b0);
    idle(4);
    // Blank mid-frame for six cycles.
    go_to(1, 2);
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 2'd0, 7'h00, 1'b1);
    idle(8);
    // Reset while digit 3 is active, then one empty frame.
    go_to(3, 1);
    cyc(1'b1, 1'b0, 2'd0, 7'h00, 1'b0);
    idle(18);
    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      cyc(($urandom_range(0, 63) == 0), ($urandom_range(0, 2) == 0),
          2'($urandom_range(0, 3)), 7'($urandom_range(0, 127)),
          ($urandom_range(0, 7) == 0));
    end
    idle(2);
    @(posedge clk);
    #2;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
